// File: rtl/bram_tdp_split_pkg.sv
// bram_tdp_split_pkg: shared FSM state and lane count for the split TDP BRAM responder
package bram_tdp_split_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int NUM_LANES = 2;
endpackage

// File: rtl/bram_tdp_split_lane.sv
// bram_tdp_split_lane: one lane memory with A/B write and read channels, A-wins collision, read-first
module bram_tdp_split_lane #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rce_a,
  input  logic [ADDR_WIDTH-1:0] i_ra_a,
  input  logic                  i_rce_b,
  input  logic [ADDR_WIDTH-1:0] i_ra_b,
  input  logic                  i_wce_a,
  input  logic [ADDR_WIDTH-1:0] i_wa_a,
  input  logic [DATA_WIDTH-1:0] i_wd_a,
  input  logic                  i_wce_b,
  input  logic [ADDR_WIDTH-1:0] i_wa_b,
  input  logic [DATA_WIDTH-1:0] i_wd_b,
  output logic [DATA_WIDTH-1:0] o_rq_a,
  output logic [DATA_WIDTH-1:0] o_rq_b,
  output logic                  o_coll
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic w_coll;
  assign w_coll = i_wce_a && i_wce_b && (i_wa_a == i_wa_b);
  always_ff @(posedge clk) begin
    if (i_wce_a) r_mem[i_wa_a] <= i_wd_a;
    if (i_wce_b && !w_coll) r_mem[i_wa_b] <= i_wd_b;
  end
  // Reads sample the array before this edge's writes land, giving read-first
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rq_a <= '0;
      o_rq_b <= '0;
      o_coll <= 1'b0;
    end else begin
      if (i_rce_a) o_rq_a <= r_mem[i_ra_a];
      if (i_rce_b) o_rq_b <= r_mem[i_ra_b];
      o_coll <= w_coll;
    end
  end
endmodule

// File: rtl/bram_tdp_split_responder.sv
// bram_tdp_split_responder: two-lane split TDP memory responder with post-reset hardware clear
module bram_tdp_split_responder
  import bram_tdp_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rce_a_0,
  input  logic [ADDR_WIDTH-1:0] ra_a_0,
  output logic [DATA_WIDTH-1:0] rq_a_0,
  input  logic                  wce_a_0,
  input  logic [ADDR_WIDTH-1:0] wa_a_0,
  input  logic [DATA_WIDTH-1:0] wd_a_0,
  input  logic                  rce_b_0,
  input  logic [ADDR_WIDTH-1:0] ra_b_0,
  output logic [DATA_WIDTH-1:0] rq_b_0,
  input  logic                  wce_b_0,
  input  logic [ADDR_WIDTH-1:0] wa_b_0,
  input  logic [DATA_WIDTH-1:0] wd_b_0,
  input  logic                  rce_a_1,
  input  logic [ADDR_WIDTH-1:0] ra_a_1,
  output logic [DATA_WIDTH-1:0] rq_a_1,
  input  logic                  wce_a_1,
  input  logic [ADDR_WIDTH-1:0] wa_a_1,
  input  logic [DATA_WIDTH-1:0] wd_a_1,
  input  logic                  rce_b_1,
  input  logic [ADDR_WIDTH-1:0] ra_b_1,
  output logic [DATA_WIDTH-1:0] rq_b_1,
  input  logic                  wce_b_1,
  input  logic [ADDR_WIDTH-1:0] wa_b_1,
  input  logic [DATA_WIDTH-1:0] wd_b_1,
  output logic                  coll_0,
  output logic                  coll_1,
  output logic                  ready
);
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_nxt;
  logic                  w_clr, w_run;
  logic [NUM_LANES-1:0]                 w_rce_a, w_rce_b, w_wce_a, w_wce_b, w_coll;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] w_ra_a, w_ra_b, w_wa_a, w_wa_b;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_wd_a, w_wd_b, w_rq_a, w_rq_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_addr;
    w_state_nxt = (r_state == CLEAR && &r_clr_addr) ? RUN : r_state;
    w_clr_nxt   = (r_state == CLEAR) ? r_clr_addr + 1'b1 : r_clr_addr;
  end
  assign ready = (r_state == RUN);
  assign w_clr = !rst && r_state == CLEAR;
  assign w_run = !rst && r_state == RUN;
  assign w_rce_a = {rce_a_1, rce_a_0};
  assign w_rce_b = {rce_b_1, rce_b_0};
  assign w_wce_a = {wce_a_1, wce_a_0};
  assign w_wce_b = {wce_b_1, wce_b_0};
  assign w_ra_a  = {ra_a_1, ra_a_0};
  assign w_ra_b  = {ra_b_1, ra_b_0};
  assign w_wa_a  = {wa_a_1, wa_a_0};
  assign w_wa_b  = {wa_b_1, wa_b_0};
  assign w_wd_a  = {wd_a_1, wd_a_0};
  assign w_wd_b  = {wd_b_1, wd_b_0};
  // Clear sequence borrows port A of every lane; port B and reads stay idle until RUN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bram_tdp_split_lane #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_rce_a (w_run & w_rce_a[i]),
      .i_ra_a  (w_ra_a[i]),
      .i_rce_b (w_run & w_rce_b[i]),
      .i_ra_b  (w_ra_b[i]),
      .i_wce_a (w_clr | (w_run & w_wce_a[i])),
      .i_wa_a  (w_clr ? r_clr_addr : w_wa_a[i]),
      .i_wd_a  (w_clr ? '0 : w_wd_a[i]),
      .i_wce_b (w_run & w_wce_b[i]),
      .i_wa_b  (w_wa_b[i]),
      .i_wd_b  (w_wd_b[i]),
      .o_rq_a  (w_rq_a[i]),
      .o_rq_b  (w_rq_b[i]),
      .o_coll  (w_coll[i])
    );
  end
  assign rq_a_0 = w_rq_a[0];
  assign rq_b_0 = w_rq_b[0];
  assign rq_a_1 = w_rq_a[1];
  assign rq_b_1 = w_rq_b[1];
  assign coll_0 = w_coll[0];
  assign coll_1 = w_coll[1];
endmodule

// File: tb/tb_bram_tdp_split_responder.sv
// tb_bram_tdp_split_responder: directed checks of clear, split fill/readback, collision, read-first, reset
module tb_bram_tdp_split_responder;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rce_a_0, rce_b_0, rce_a_1, rce_b_1;
  logic wce_a_0, wce_b_0, wce_a_1, wce_b_1;
  logic [AW-1:0] ra_a_0, ra_b_0, ra_a_1, ra_b_1, wa_a_0, wa_b_0, wa_a_1, wa_b_1;
  logic [DW-1:0] wd_a_0, wd_b_0, wd_a_1, wd_b_1, rq_a_0, rq_b_0, rq_a_1, rq_b_1;
  logic coll_0, coll_1, ready;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  bram_tdp_split_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .rce_a_0(rce_a_0), .ra_a_0(ra_a_0), .rq_a_0(rq_a_0),
    .wce_a_0(wce_a_0), .wa_a_0(wa_a_0), .wd_a_0(wd_a_0),
    .rce_b_0(rce_b_0), .ra_b_0(ra_b_0), .rq_b_0(rq_b_0),
    .wce_b_0(wce_b_0), .wa_b_0(wa_b_0), .wd_b_0(wd_b_0),
    .rce_a_1(rce_a_1), .ra_a_1(ra_a_1), .rq_a_1(rq_a_1),
    .wce_a_1(wce_a_1), .wa_a_1(wa_a_1), .wd_a_1(wd_a_1),
    .rce_b_1(rce_b_1), .ra_b_1(ra_b_1), .rq_b_1(rq_b_1),
    .wce_b_1(wce_b_1), .wa_b_1(wa_b_1), .wd_b_1(wd_b_1),
    .coll_0(coll_0), .coll_1(coll_1), .ready(ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [DW-1:0] pat(input int x);
    logic [31:0] v;
    v = x | (x << 20) | 32'h55000;
    return v[DW-1:0];
  endfunction
  function automatic logic [DW-1:0] exp0(input int x);
    return (x < 512) ? pat(x) : pat(x + 2);
  endfunction
  function automatic logic [DW-1:0] exp1(input int x);
    return (x < 512) ? pat(x + 1) : pat(x + 3);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    {rce_a_0, rce_b_0, rce_a_1, rce_b_1} = '0;
    {wce_a_0, wce_b_0, wce_a_1, wce_b_1} = '0;
    {ra_a_0, ra_b_0, ra_a_1, ra_b_1} = '0;
    {wa_a_0, wa_b_0, wa_a_1, wa_b_1} = '0;
    {wd_a_0, wd_b_0, wd_a_1, wd_b_1} = '0;
  endtask
  task automatic reset_and_clear(input string tag);
    rst = 1'b1;
    tick();
    check({tag, " rst ready"}, 32'(ready), 32'd0);
    check({tag, " rst rq_a_0"}, 32'(rq_a_0), 32'd0);
    check({tag, " rst rq_b_0"}, 32'(rq_b_0), 32'd0);
    check({tag, " rst coll_0"}, 32'(coll_0), 32'd0);
    rst = 1'b0;
    {rce_a_0, rce_b_0, rce_a_1, rce_b_1} = '1;
    ra_a_0 = AW'(3); ra_b_0 = AW'(7); ra_a_1 = AW'(3); ra_b_1 = AW'(7);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == DEPTH - 1) check({tag, " ready@1023"}, 32'(ready), 32'd0);
      if (k == DEPTH) begin
        check({tag, " ready@1024"}, 32'(ready), 32'd1);
        check({tag, " clr rq_a_0"}, 32'(rq_a_0), 32'd0);
        check({tag, " clr rq_b_1"}, 32'(rq_b_1), 32'd0);
      end
    end
    idle();
  endtask
  task automatic read_all(input bit zero);
    for (int a = 0; a < DEPTH; a++) begin
      {rce_a_0, rce_b_0, rce_a_1, rce_b_1} = '1;
      ra_a_0 = AW'(a); ra_a_1 = AW'(a);
      ra_b_0 = AW'(DEPTH - 1 - a); ra_b_1 = AW'(DEPTH - 1 - a);
      tick();
      check($sformatf("rd a0[%0d]", a), 32'(rq_a_0), zero ? 32'd0 : 32'(exp0(a)));
      check($sformatf("rd a1[%0d]", a), 32'(rq_a_1), zero ? 32'd0 : 32'(exp1(a)));
      check($sformatf("rd b0[%0d]", DEPTH - 1 - a), 32'(rq_b_0), zero ? 32'd0 : 32'(exp0(DEPTH - 1 - a)));
      check($sformatf("rd b1[%0d]", DEPTH - 1 - a), 32'(rq_b_1), zero ? 32'd0 : 32'(exp1(DEPTH - 1 - a)));
    end
    idle();
  endtask
  initial begin
    idle();
    reset_and_clear("init");
    for (int i = 0; i < 512; i++) begin
      wce_a_0 = 1'b1; wce_a_1 = 1'b1; wce_b_0 = 1'b1; wce_b_1 = 1'b1;
      wa_a_0 = AW'(i); wa_a_1 = AW'(i);
      wa_b_0 = AW'(512 + i); wa_b_1 = AW'(512 + i);
      wd_a_0 = pat(i); wd_a_1 = pat(i + 1);
      wd_b_0 = pat(512 + i + 2); wd_b_1 = pat(512 + i + 3);
      tick();
      if (i == 0) check("fill coll_0", 32'(coll_0), 32'd0);
    end
    idle();
    read_all(1'b0);
    wce_a_0 = 1'b1; wce_b_0 = 1'b1;
    wa_a_0 = AW'('h10); wa_b_0 = AW'('h10);
    wd_a_0 = 18'h3FFFF; wd_b_0 = 18'h00001;
    tick();
    check("coll_0 pulse", 32'(coll_0), 32'd1);
    check("coll_1 quiet", 32'(coll_1), 32'd0);
    idle();
    rce_a_0 = 1'b1; ra_a_0 = AW'('h10);
    rce_a_1 = 1'b1; ra_a_1 = AW'('h10);
    tick();
    check("coll_0 one cycle", 32'(coll_0), 32'd0);
    check("coll A wins", 32'(rq_a_0), 32'h3FFFF);
    check("coll lane1 untouched", 32'(rq_a_1), 32'(pat('h11)));
    idle();
    wce_b_0 = 1'b1; wa_b_0 = AW'(5); wd_b_0 = 18'h00AAA;
    tick();
    idle();
    wce_a_0 = 1'b1; wa_a_0 = AW'(5); wd_a_0 = 18'h15555;
    rce_b_0 = 1'b1; ra_b_0 = AW'(5);
    tick();
    check("rdw old word", 32'(rq_b_0), 32'h00AAA);
    idle();
    rce_b_0 = 1'b1; ra_b_0 = AW'(5);
    tick();
    check("rdw new word", 32'(rq_b_0), 32'h15555);
    idle();
    ra_b_0 = AW'(0); ra_a_0 = AW'(0);
    tick();
    tick();
    check("hold rq_b_0", 32'(rq_b_0), 32'h15555);
    check("hold rq_a_0", 32'(rq_a_0), 32'h3FFFF);
    reset_and_clear("mid");
    read_all(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
